// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that shares one external carry-select Add_Sub adder among
// NUM_REQ requesters and returns each result on a valid/ready response port.
module addsub_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]            req_sub,
   output logic [DATA_WIDTH-1:0]         add_a,
   output logic [DATA_WIDTH-1:0]         add_b,
   output logic                          add_cin,
   input  logic [DATA_WIDTH-1:0]         add_result,
   input  logic                          add_overflow,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic                          rsp_overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ID_W-1:0]       r_rr_ptr;
   logic [ID_W-1:0]       r_id;
   logic [DATA_WIDTH-1:0] r_add_a;
   logic [DATA_WIDTH-1:0] r_add_b;
   logic                  r_add_cin;
   logic                  r_rsp_valid;
   logic [ID_W-1:0]       r_rsp_id;
   logic [DATA_WIDTH-1:0] r_rsp_result;
   logic                  r_rsp_overflow;

   logic                  w_any;
   logic [ID_W-1:0]       w_grant_id;
   logic [ID_W-1:0]       w_idx;
   int                    w_sum;
   logic [ID_W-1:0]       w_rr_nxt;
   logic [DATA_WIDTH-1:0] w_sel_a;
   logic [DATA_WIDTH-1:0] w_sel_b;
   logic                  w_sel_sub;
   logic [NUM_REQ-1:0]    w_req_ready;

   // Rotating priority search: walking k downward lets the closest index to rr_ptr win.
   always_comb begin
      w_any      = 1'b0;
      w_grant_id = {ID_W{1'b0}};
      w_idx      = {ID_W{1'b0}};
      w_sum      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum      = int'(r_rr_ptr) + k;
         w_idx      = (w_sum >= NUM_REQ) ? ID_W'(w_sum - NUM_REQ) : ID_W'(w_sum);
         w_any      = w_any | req_valid[w_idx];
         w_grant_id = req_valid[w_idx] ? w_idx : w_grant_id;
      end
      w_rr_nxt  = (int'(w_grant_id) == NUM_REQ - 1) ? {ID_W{1'b0}} : w_grant_id + ID_W'(1);
      w_sel_a   = req_a[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
      w_sel_b   = req_b[int'(w_grant_id)*DATA_WIDTH +: DATA_WIDTH];
      w_sel_sub = req_sub[w_grant_id];
   end

   // Next-state logic and the one-cycle accept strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = {NUM_REQ{1'b0}};
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt             = S_EXEC;
               w_req_ready[w_grant_id] = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = rsp_ready ? S_IDLE : S_RESP;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, pointer, adder operands and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_rr_ptr       <= {ID_W{1'b0}};
         r_id           <= {ID_W{1'b0}};
         r_add_a        <= {DATA_WIDTH{1'b0}};
         r_add_b        <= {DATA_WIDTH{1'b0}};
         r_add_cin      <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_id       <= {ID_W{1'b0}};
         r_rsp_result   <= {DATA_WIDTH{1'b0}};
         r_rsp_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  // Subtraction is A + ~B + 1 so the shared adder never changes mode.
                  r_add_a   <= w_sel_a;
                  r_add_b   <= w_sel_sub ? ~w_sel_b : w_sel_b;
                  r_add_cin <= w_sel_sub;
                  r_id      <= w_grant_id;
                  r_rr_ptr  <= w_rr_nxt;
               end else begin
                  r_rr_ptr <= r_rr_ptr;
               end
            end
            S_EXEC: begin
               r_rsp_result   <= add_result;
               r_rsp_overflow <= add_overflow;
               r_rsp_id       <= r_id;
               r_rsp_valid    <= 1'b1;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
               end else begin
                  r_rsp_valid <= 1'b1;
               end
            end
            default: r_rsp_valid <= 1'b0;
         endcase
      end
   end

   assign req_ready    = w_req_ready;
   assign add_a        = r_add_a;
   assign add_b        = r_add_b;
   assign add_cin      = r_add_cin;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_id       = r_rsp_id;
   assign rsp_result   = r_rsp_result;
   assign rsp_overflow = r_rsp_overflow;

endmodule
